// File: rtl/regfile_scoreboard.sv
//==============================================================================
// Module      : regfile_scoreboard
// Description : Issue-side hazard controller and write-port arbiter for the
//               32x32 register file (x0 hardwired zero).
//               - One pending-write bit per architectural register.
//               - Decode is stalled on RAW/WAW hazards against in-flight
//                 writes.
//               - The single register-file write port is shared between
//                 wb0 (ALU/CSR) and wb1 (load unit) with a round-robin
//                 arbiter. After reset, wb0 has priority.
// Ports       : clk, reset_n (async, active-low)
//               issue_*      : decode handshake and operand/destination info
//               wb0_*, wb1_* : writeback requests, combinational grants
//               rf_rd_*      : register-file write port (lands on falling clk)
//               pending, busy, wb_unexpected : status
// Option      : `define SCOREBOARD_BYPASS_EN so that a register cleared by
//               this cycle's grant counts as not pending for issue_ready in
//               the same cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv;
   typedef logic [4:0]  addr_t;
   typedef logic [31:0] word_t;
endpackage

module regfile_scoreboard (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         issue_valid,
   output logic         issue_ready,
   input  riscv::addr_t issue_rs1,
   input  riscv::addr_t issue_rs2,
   input  logic         issue_rs1_use,
   input  logic         issue_rs2_use,
   input  riscv::addr_t issue_rd,
   input  logic         issue_rd_en,
   input  logic         wb0_valid,
   input  logic         wb1_valid,
   output logic         wb0_ready,
   output logic         wb1_ready,
   input  riscv::addr_t wb0_addr,
   input  riscv::addr_t wb1_addr,
   input  riscv::word_t wb0_data,
   input  riscv::word_t wb1_data,
   output logic         rf_rd_en,
   output riscv::addr_t rf_rd_addr,
   output riscv::word_t rf_rd_data,
   output logic [31:0]  pending,
   output logic         busy,
   output logic         wb_unexpected
);

   // Round-robin pointer: 1 means wb1 wins the next contested cycle.
   logic         prio_wb1;

   logic         grant0;
   logic         grant1;
   logic         wb_write;
   logic [31:0]  clr_mask;
   logic [31:0]  set_mask;
   logic [31:0]  hazard_view;
   logic [31:0]  pending_next;
   logic         issue_fire;

   // Arbiter: a lone requester always wins; contention goes by the pointer.
   always_comb begin
      grant0 = wb0_valid && (!wb1_valid || !prio_wb1);
      grant1 = wb1_valid && (!wb0_valid ||  prio_wb1);
   end

   // Write port mux; when nothing is granted the wb0 payload is presented
   // but rf_rd_en stays low.
   always_comb begin
      rf_rd_addr = grant1 ? wb1_addr : wb0_addr;
      rf_rd_data = grant1 ? wb1_data : wb0_data;
      wb_write   = (grant0 || grant1) && (rf_rd_addr != 5'd0);
   end

   assign wb0_ready = grant0;
   assign wb1_ready = grant1;
   assign rf_rd_en  = wb_write;

   always_comb begin
      clr_mask = '0;
      if (wb_write) begin
         clr_mask = 32'd1 << rf_rd_addr;
      end
   end

`ifdef SCOREBOARD_BYPASS_EN
   // The falling-edge register-file write makes the value readable before
   // the next rising edge, so a register being retired this cycle is safe.
   assign hazard_view = pending & ~clr_mask;
`else
   assign hazard_view = pending;
`endif

   // x0 is never pending, so no special casing is needed for it here.
   always_comb begin
      issue_ready = !((issue_rs1_use && hazard_view[issue_rs1]) ||
                      (issue_rs2_use && hazard_view[issue_rs2]) ||
                      (issue_rd_en   && hazard_view[issue_rd]));
   end

   assign issue_fire = issue_valid && issue_ready;

   always_comb begin
      set_mask = '0;
      if (issue_fire && issue_rd_en && (issue_rd != 5'd0)) begin
         set_mask = 32'd1 << issue_rd;
      end
   end

   // Clear first, then set: a same-cycle set of the same register wins.
   assign pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;

   assign busy = |pending;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending       <= '0;
         wb_unexpected <= 1'b0;
         prio_wb1      <= 1'b0;
      end else begin
         pending <= pending_next;
         if (wb_write && !pending[rf_rd_addr]) begin
            wb_unexpected <= 1'b1;
         end
         if (grant0) begin
            prio_wb1 <= 1'b1;
         end else if (grant1) begin
            prio_wb1 <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
//==============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard. A driver applies
//               directed then random cycles, predicts every visible output
//               from a register-level reference model and queues the
//               prediction; a monitor pops and compares on each falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_scoreboard;

   typedef struct {
      bit          ir;
      bit          r0;
      bit          r1;
      bit          en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pend;
      bit          busy;
      bit          unexp;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         issue_valid = 1'b0;
   logic         issue_ready;
   riscv::addr_t issue_rs1 = '0;
   riscv::addr_t issue_rs2 = '0;
   logic         issue_rs1_use = 1'b0;
   logic         issue_rs2_use = 1'b0;
   riscv::addr_t issue_rd = '0;
   logic         issue_rd_en = 1'b0;
   logic         wb0_valid = 1'b0;
   logic         wb1_valid = 1'b0;
   logic         wb0_ready;
   logic         wb1_ready;
   riscv::addr_t wb0_addr = '0;
   riscv::addr_t wb1_addr = '0;
   riscv::word_t wb0_data = '0;
   riscv::word_t wb1_data = '0;
   logic         rf_rd_en;
   riscv::addr_t rf_rd_addr;
   riscv::word_t rf_rd_data;
   logic [31:0]  pending;
   logic         busy;
   logic         wb_unexpected;

   regfile_scoreboard dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rs1_use (issue_rs1_use),
      .issue_rs2_use (issue_rs2_use),
      .issue_rd      (issue_rd),
      .issue_rd_en   (issue_rd_en),
      .wb0_valid     (wb0_valid),
      .wb1_valid     (wb1_valid),
      .wb0_ready     (wb0_ready),
      .wb1_ready     (wb1_ready),
      .wb0_addr      (wb0_addr),
      .wb1_addr      (wb1_addr),
      .wb0_data      (wb0_data),
      .wb1_data      (wb1_data),
      .rf_rd_en      (rf_rd_en),
      .rf_rd_addr    (rf_rd_addr),
      .rf_rd_data    (rf_rd_data),
      .pending       (pending),
      .busy          (busy),
      .wb_unexpected (wb_unexpected)
   );

   always #5 clk = ~clk;

   // Reference model state: which registers await a write, which source
   // has the next contested grant, and the sticky anomaly flag.
   bit   m_pend[32];
   int   m_prefer;   // 0 -> wb0 wins contention, 1 -> wb1 wins
   bit   m_unexp;
   bit   bypass;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_prefer = 0;
      m_unexp  = 1'b0;
   endtask

   // Apply one cycle of stimulus (called at posedge+1), predict, advance model.
   task automatic step(input bit iv, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rden,
                       input bit v0, input int a0, input logic [31:0] d0,
                       input bit v1, input int a1, input logic [31:0] d1);
      exp_t e;
      bit   g0, g1, busy_m;
      int   ga;
      bit   blocked;
      issue_valid = iv;  issue_rs1 = 5'(rs1); issue_rs1_use = u1;
      issue_rs2 = 5'(rs2); issue_rs2_use = u2; issue_rd = 5'(rd); issue_rd_en = rden;
      wb0_valid = v0; wb0_addr = 5'(a0); wb0_data = d0;
      wb1_valid = v1; wb1_addr = 5'(a1); wb1_data = d1;

      if (v0 && v1) g0 = (m_prefer == 0);
      else          g0 = v0;
      g1 = v1 && !g0;
      ga = g1 ? a1 : a0;
      e.r0   = g0;
      e.r1   = g1;
      e.en   = (g0 || g1) && (ga != 0);
      e.addr = 5'(ga);
      e.data = g1 ? d1 : d0;

      blocked = 1'b0;
      if (u1   && m_pend[rs1] && !(bypass && e.en && ga == rs1)) blocked = 1'b1;
      if (u2   && m_pend[rs2] && !(bypass && e.en && ga == rs2)) blocked = 1'b1;
      if (rden && m_pend[rd]  && !(bypass && e.en && ga == rd))  blocked = 1'b1;
      e.ir = !blocked;

      busy_m = 1'b0;
      for (int i = 0; i < 32; i++) begin
         e.pend[i] = m_pend[i];
         if (m_pend[i]) busy_m = 1'b1;
      end
      e.busy  = busy_m;
      e.unexp = m_unexp;
      exp_q.push_back(e);

      // Model update for the coming rising edge.
      if (g0) m_prefer = 1;
      if (g1) m_prefer = 0;
      if (e.en) begin
         if (!m_pend[ga]) m_unexp = 1'b1;
         m_pend[ga] = 1'b0;
      end
      if (iv && e.ir && rden && rd != 0) m_pend[rd] = 1'b1;

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest prediction.
   initial begin
      exp_t e;
      bit   ok;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (issue_ready === e.ir) && (wb0_ready === e.r0) && (wb1_ready === e.r1) &&
                 (rf_rd_en === e.en) && (pending === e.pend) && (busy === e.busy) &&
                 (wb_unexpected === e.unexp);
            if (e.r0 || e.r1) ok = ok && (rf_rd_addr === e.addr) && (rf_rd_data === e.data);
            total++;
            if (ok) passed++;
            else $display("FAIL cycle t=%0t: got ir=%b g0=%b g1=%b en=%b a=%0d d=%h pend=%h busy=%b unx=%b, required ir=%b g0=%b g1=%b en=%b a=%0d d=%h pend=%h busy=%b unx=%b",
                          $time, issue_ready, wb0_ready, wb1_ready, rf_rd_en, rf_rd_addr, rf_rd_data,
                          pending, busy, wb_unexpected, e.ir, e.r0, e.r1, e.en, e.addr, e.data,
                          e.pend, e.busy, e.unexp);
         end
      end
   end

   initial begin
      int plist[$];
      int a0, a1;
`ifdef SCOREBOARD_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      model_reset();

      // Reset state.
      #3;
      chk("reset_issue_ready", 32'(issue_ready), 32'd1);
      chk("reset_pending", pending, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_unexpected", 32'(wb_unexpected), 32'd0);
      chk("reset_rf_en", 32'(rf_rd_en), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Issue rd=5, then a dependent instruction stalls.
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
      step(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      // wb1 retires x5.
      step(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF);
      step(1, 5, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle();
      // Contention for four cycles alternates grants.
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1000 + 32'(i), 1, 2, 32'h2000 + 32'(i));
      // Destination x0 sets nothing; writeback to x0 is consumed silently.
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0, 0);
      // Writeback to a non-pending register raises the sticky flag.
      step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hCAFEF00D, 0, 0, 0);
      idle();
      // Same-cycle set and clear of x9.
      step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 9, 1, 1, 9, 32'h99, 0, 0, 0);
      idle();

      // Reset asserted mid-cycle clears state immediately.
      step(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
      issue_valid = 1'b0; issue_rd_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_pending", pending, 32'd0);
      chk("async_reset_busy", 32'(busy), 32'd0);
      chk("async_reset_unexpected", 32'(wb_unexpected), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
      // Pointer back on wb0 after reset.
      step(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hA, 1, 4, 32'hB);

      // Randomized traffic; writebacks usually target a pending register.
      for (int n = 0; n < 400; n++) begin
         plist.delete();
         for (int i = 1; i < 32; i++) if (m_pend[i]) plist.push_back(i);
         a0 = (plist.size() > 0 && $urandom_range(3) != 0) ? plist[$urandom_range(plist.size()-1)]
                                                           : int'($urandom_range(31));
         a1 = (plist.size() > 0 && $urandom_range(3) != 0) ? plist[$urandom_range(plist.size()-1)]
                                                           : int'($urandom_range(31));
         step($urandom_range(1), $urandom_range(31), $urandom_range(1),
              $urandom_range(31), $urandom_range(1), $urandom_range(31), $urandom_range(1),
              ($urandom_range(2) == 0), a0, $urandom,
              ($urandom_range(2) == 0), a1, $urandom);
      end
      idle();

      @(negedge clk); #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
